// File: rtl/feature_vector_loader_if.sv
// Feature stream (valid/ready) plus parallel core handshake between host/DMA, loader and inference core.
interface feature_vector_loader_if #(
  parameter int WIDTH      = 25,
  parameter int INPUT_SIZE = 16
);
  logic                             s_valid;
  logic                             s_ready;
  logic signed [WIDTH-1:0]          s_data;
  logic                             s_last;
  logic                             net_input_ready;
  logic [INPUT_SIZE-1:0][WIDTH-1:0] net_input_data;
  logic                             net_output_ready;

  // Host/core side: supplies beats and completion, observes the vector.
  modport master (
    output s_valid, s_data, s_last, net_output_ready,
    input  s_ready, net_input_ready, net_input_data
  );

  modport slave (
    input  s_valid, s_data, s_last, net_output_ready,
    output s_ready, net_input_ready, net_input_data
  );
endinterface

// File: rtl/feature_vector_loader.sv
// Packs a beat-per-feature stream into a held parallel vector, strobes the MLP core and waits for completion.
// Optional WAIT timeout: define FEATURE_LOADER_TIMEOUT_EN.
module feature_vector_loader #(
  parameter int WIDTH          = 25,
  parameter int NFRAC          = 16,
  parameter int INPUT_SIZE     = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                   clk,
  input  logic                   reset,
  feature_vector_loader_if.slave bus,
  output logic                   busy,
  output logic                   frame_err,
  output logic [15:0]            frames_done,
  output logic                   timeout_err
);
  localparam int            IW       = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(INPUT_SIZE - 1);

  typedef enum logic [1:0] {FILL, FIRE, WAIT} state_t;

  state_t                           r_state, w_next;
  logic [IW-1:0]                    r_idx;
  logic [INPUT_SIZE-1:0][WIDTH-1:0] r_vec;
  logic                             r_s_ready;
  logic                             r_prev;
  logic                             r_frame_err;
  logic [15:0]                      r_frames_done;
  logic                             w_accept, w_complete, w_timeout, w_at_last;

  // Fraction bits must fit in the word; nothing else depends on NFRAC.
  if (NFRAC > WIDTH || TIMEOUT_CYCLES < 1) begin : g_bad_params
  end

  assign w_accept   = bus.s_valid && r_s_ready;
  assign w_at_last  = (r_idx == LAST_IDX);
  assign w_complete = (r_state == WAIT) && bus.net_output_ready && !r_prev;

`ifdef FEATURE_LOADER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_wcnt;
  logic          r_timeout_err;

  // Counter sits at zero outside WAIT, so it is clear on WAIT entry.
  always_ff @(posedge clk) begin
    if (reset || r_state != WAIT) r_wcnt <= '0;
    else                          r_wcnt <= r_wcnt + CW'(1);
  end

  assign w_timeout = (r_state == WAIT) && !w_complete && (r_wcnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) r_timeout_err <= 1'b0;
    else       r_timeout_err <= w_timeout;
  end

  assign timeout_err = r_timeout_err;
`else
  assign w_timeout   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      FILL:    if (w_accept && w_at_last) w_next = FIRE;
      FIRE:    w_next = WAIT;
      WAIT:    if (w_complete || w_timeout) w_next = FILL;
      default: w_next = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= FILL;
      r_idx         <= '0;
      r_s_ready     <= 1'b0;
      r_prev        <= 1'b0;
      r_frame_err   <= 1'b0;
      r_frames_done <= '0;
    end else begin
      r_state     <= w_next;
      r_s_ready   <= (w_next == FILL);
      r_prev      <= bus.net_output_ready;
      // Error when s_last disagrees with the beat position: early or missing.
      r_frame_err <= w_accept && (bus.s_last != w_at_last);
      if (w_accept) r_idx <= (w_at_last || bus.s_last) ? '0 : r_idx + IW'(1);
      if (w_complete) r_frames_done <= r_frames_done + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vec <= '0;
    end else if (w_accept) begin
      for (int i = 0; i < INPUT_SIZE; i++)
        if (r_idx == IW'(i)) r_vec[i] <= bus.s_data;
    end
  end

  assign bus.s_ready         = r_s_ready;
  assign bus.net_input_ready = (r_state == FIRE);
  assign bus.net_input_data  = r_vec;
  assign busy                = (r_state == FIRE) || (r_state == WAIT);
  assign frame_err           = r_frame_err;
  assign frames_done         = r_frames_done;
endmodule
